mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit memory port between two requesters.
- Port 0 is the instruction/data controller (fetch, operand fetch, store).
- Port 1 is the program loader / IO master that writes images into memory or reads results.
- Sits between both masters and the memory, with registered ownership, round-robin fairness, a lock for multi-cycle sequences, and a hold limit.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- MAX_HOLD, 16, cycles an unlocked owner may keep the bus while the other port waits (range 1..255).
- PROTECT_TOP, 8'h3F, highest address protected from port 1 writes (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req0  in  1  port 0 requests the bus.
- lock0  in  1  port 0 keeps its grant across a multi-cycle sequence.
- we0  in  1  port 0 write strobe.
- addr0  in  AW  port 0 address.
- wdata0  in  DW  port 0 write data.
- gnt0  out  1  port 0 owns the bus.
- req1, lock1, we1, addr1, wdata1, gnt1: same as port 0, for port 1.
- rdata  out  DW  read data from memory, broadcast to both ports; valid for the owner only.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_write  out  1  memory write enable.
- mem_rdata  in  DW  memory read data (combinational read).
- prot_err  out  1  sticky protection violation; tied 0 when the optional feature is compiled out.

Behaviour:
- State machine states: IDLE, OWN0, OWN1.
- Registers:
  - state, reset to IDLE.
  - last_owner, reset to 1, so port 0 wins the first tie.
  - hold_cnt, 8 bits, reset to 0.
  - prot_err, reset to 0.
- Reset is asynchronous. Asserting it mid-access forces gnt0 = gnt1 = 0 and mem_write = 0 immediately; any in-flight access is abandoned.
- gnt0 = (state == OWN0) and gnt1 = (state == OWN1), both decoded from registered state, never from req.
- Grant latency is 1 cycle: a request sampled at edge N gives ownership from edge N on, so gnt is visible in the following cycle.
- Datapath mux, combinational from state:
  - In OWNx: mem_addr = addrx, mem_wdata = wdatax, mem_write = wex.
  - In IDLE: all three driven to 0.
  - rdata = mem_rdata at all times.
- IDLE transitions:
  - Only req0 high: go to OWN0.
  - Only req1 high: go to OWN1.
  - Both high: go to the port that is not last_owner.
  - Neither high: stay in IDLE.
- Entering OWNx sets last_owner = x and hold_cnt = 0.
- OWNx, per cycle:
  - Release condition: !reqx && !lockx.
  - Preempt condition: reqy && !lockx && (hold_cnt >= MAX_HOLD - 1), where y is the other port.
  - On release or preempt: if reqy, hand off directly to OWNy (no IDLE bubble); otherwise go to IDLE.
  - Otherwise stay in OWNx. hold_cnt increments while reqy is high and saturates at 255; it holds while reqy is low.
- lockx high overrides both release and preempt, even with reqx low. The owner must drop lock to yield.
- Both ports requesting continuously with no locks: grants alternate every MAX_HOLD cycles.
- we on a port that is not granted is ignored; it is never forwarded to memory.

Optional Feature:
- Macro: MEM_BUS_ARBITER_WRITE_PROTECT_EN.
- Defined:
  - In OWN1 with we1 high and addr1 <= PROTECT_TOP: mem_write is forced to 0 and prot_err is set.
  - prot_err is sticky until reset.
  - Port 0 is never protected.
- Not defined: no address comparison, and prot_err is constant 0.

Decomposition:
- Shared package / header holds:
  - state encodings ARB_IDLE = 2'd0, ARB_OWN0 = 2'd1, ARB_OWN1 = 2'd2.
  - Default widths (AW, DW).
- A single sub-module, mem_bus_mux, is natural: the combinational addr/wdata/write selection by state, plus the protect gating.
- Arbitration FSM and counters stay in the top module.

Test Plan:
- Reset, then req0 = 1 alone, addr0 = 8'h05 -> gnt0 = 1 the next cycle, mem_addr = 8'h05, rdata = mem[5], gnt1 = 0.
- req0 and req1 rise together from IDLE after reset -> port 0 granted first. Port 0 drops req -> gnt1 the next cycle with no IDLE cycle, last_owner = 1.
- Port 0 holds req with lock0 = 0, req1 = 1, MAX_HOLD = 4 -> gnt0 drops after 4 owned cycles and gnt1 rises the following cycle.
- Port 0 asserts lock0 = 1 with req0 = 0 while req1 = 1 for 20 cycles -> gnt0 stays 1 throughout. Dropping lock0 -> gnt1 the next cycle.
- Port 1 owning, we1 = 1, addr1 = 8'h10, wdata1 = 8'hAA -> with the macro: mem_write = 0 and prot_err = 1, sticky. Without the macro: mem[8'h10] = 8'hAA and prot_err = 0.
- Assert reset during a port 1 write -> mem_write = 0 and gnt1 = 0 in the same cycle. After release: state IDLE, first tie goes to port 0.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the two-port memory bus arbiter: state encoding, default widths
// and a saturating counter helper.
package mem_bus_arbiter_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the memory.
// Handshake: reqx asks for the bus and gntx answers it; every cycle gntx is high is one
// memory access by port x (a write when wex is high), and rdata is meaningful only to the owner.
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          req0;
  logic          lock0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;

  logic          req1;
  logic          lock1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;

  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;
  logic          prot_err;

  modport slave (
    input  req0, lock0, we0, addr0, wdata0,
    input  req1, lock1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rdata, mem_addr, mem_wdata, mem_write, prot_err
  );

  modport master (
    output req0, lock0, we0, addr0, wdata0,
    output req1, lock1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rdata, mem_addr, mem_wdata, mem_write, prot_err
  );

endinterface

// File: rtl/mem_bus_mux.sv
// Owner-selected address/data/write path into memory, with optional write protection
// of the low address range against port 1 (MEM_BUS_ARBITER_WRITE_PROTECT_EN).
module mem_bus_mux
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int PROTECT_TOP = 'h3F
) (
  input  arb_state_t    state,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          we0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          we1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          prot_hit
);

  if (PROTECT_TOP < 0 || PROTECT_TOP > (1 << AW) - 1) begin : g_bad_protect_top
    $error("PROTECT_TOP outside the address range");
  end

`ifdef MEM_BUS_ARBITER_WRITE_PROTECT_EN
  localparam logic [AW-1:0] PROT_LIMIT = AW'(PROTECT_TOP);
  assign prot_hit = (state == ARB_OWN1) && we1 && (addr1 <= PROT_LIMIT);
`else
  assign prot_hit = 1'b0;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    case (state)
      ARB_OWN0: begin
        mem_addr  = addr0;
        mem_wdata = wdata0;
        mem_write = we0;
      end
      ARB_OWN1: begin
        mem_addr  = addr1;
        mem_wdata = wdata1;
        mem_write = we1 && !prot_hit;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: registered ownership, round-robin ties, lock and hold limit.
// Optional port 1 write protection via MEM_BUS_ARBITER_WRITE_PROTECT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MAX_HOLD    = 16,
  parameter int PROTECT_TOP = 'h3F
) (
  input  logic                clk,
  input  logic                reset,
  mem_bus_arbiter_if.slave    bus,
  output arb_state_t          dbg_state,
  output logic                dbg_last_owner
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 1..255");
  end

  localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD - 1);

  arb_state_t state, state_nxt;
  logic       last_owner, last_owner_nxt;
  logic [7:0] hold_cnt, hold_cnt_nxt;
  logic       prot_hit;
  logic       prot_err_q;
  logic       yield0, yield1;

  // A lock pins ownership even with the request low; the owner must drop it to yield.
  assign yield0 = !bus.lock0 && (!bus.req0 || (bus.req1 && hold_cnt >= HOLD_LIMIT));
  assign yield1 = !bus.lock1 && (!bus.req1 || (bus.req0 && hold_cnt >= HOLD_LIMIT));

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    hold_cnt_nxt   = hold_cnt;
    case (state)
      ARB_IDLE: begin
        if (bus.req0 && (!bus.req1 || last_owner)) begin
          state_nxt      = ARB_OWN0;
          last_owner_nxt = 1'b0;
          hold_cnt_nxt   = '0;
        end else if (bus.req1) begin
          state_nxt      = ARB_OWN1;
          last_owner_nxt = 1'b1;
          hold_cnt_nxt   = '0;
        end
      end
      ARB_OWN0: begin
        if (yield0) begin
          hold_cnt_nxt = '0;
          if (bus.req1) begin
            state_nxt      = ARB_OWN1;
            last_owner_nxt = 1'b1;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else if (bus.req1) begin
          hold_cnt_nxt = sat_inc8(hold_cnt);
        end
      end
      ARB_OWN1: begin
        if (yield1) begin
          hold_cnt_nxt = '0;
          if (bus.req0) begin
            state_nxt      = ARB_OWN0;
            last_owner_nxt = 1'b0;
          end else begin
            state_nxt = ARB_IDLE;
          end
        end else if (bus.req0) begin
          hold_cnt_nxt = sat_inc8(hold_cnt);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_owner <= 1'b1;
      hold_cnt   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      hold_cnt   <= hold_cnt_nxt;
      if (prot_hit) prot_err_q <= 1'b1;
    end
  end

  assign bus.gnt0     = (state == ARB_OWN0);
  assign bus.gnt1     = (state == ARB_OWN1);
  assign bus.rdata    = bus.mem_rdata;
  assign bus.prot_err = prot_err_q;
  assign dbg_state      = state;
  assign dbg_last_owner = last_owner;

  mem_bus_mux #(
    .AW          (AW),
    .DW          (DW),
    .PROTECT_TOP (PROTECT_TOP)
  ) u_mux (
    .state     (state),
    .addr0     (bus.addr0),
    .wdata0    (bus.wdata0),
    .we0       (bus.we0),
    .addr1     (bus.addr1),
    .wdata1    (bus.wdata1),
    .we1       (bus.we1),
    .mem_addr  (bus.mem_addr),
    .mem_wdata (bus.mem_wdata),
    .mem_write (bus.mem_write),
    .prot_hit  (prot_hit)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed plus randomized bench for mem_bus_arbiter against a behavioural ownership model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int AW       = 8;
  localparam int DW       = 8;
  localparam int MAX_HOLD = 4;
  localparam int PROT_TOP = 'h3F;
`ifdef MEM_BUS_ARBITER_WRITE_PROTECT_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.AW(AW), .DW(DW)) bus();
  arb_state_t dbg_state;
  logic       dbg_last_owner;

  mem_bus_arbiter #(
    .AW(AW), .DW(DW), .MAX_HOLD(MAX_HOLD), .PROTECT_TOP(PROT_TOP)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus.slave),
    .dbg_state      (dbg_state),
    .dbg_last_owner (dbg_last_owner)
  );

  logic [DW-1:0] mem [256];
  assign bus.mem_rdata = mem[bus.mem_addr];

  // ---------------- reference model ----------------
  int   owner;      // -1 = nobody, else the owning port
  bit   last;       // port that owned most recently
  int   waited;     // cycles the other port has waited during this tenure
  bit   prot_exp;
  logic [AW+DW-1:0] exp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    owner = -1; last = 1'b1; waited = 0; prot_exp = 1'b0;
  endtask

  task automatic take(input int x);
    owner = x; last = x[0]; waited = 0;
  endtask

  // Apply one rising edge to the model using the inputs currently on the bus.
  task automatic model_edge();
    logic mine_req, mine_lock, other_req;
    if (owner == 1 && bus.we1 && PROT_EN && int'(bus.addr1) <= PROT_TOP) prot_exp = 1'b1;
    if (owner < 0) begin
      if (bus.req0 && bus.req1) take(last ? 0 : 1);
      else if (bus.req0)        take(0);
      else if (bus.req1)        take(1);
    end else begin
      mine_req  = (owner == 0) ? bus.req0  : bus.req1;
      mine_lock = (owner == 0) ? bus.lock0 : bus.lock1;
      other_req = (owner == 0) ? bus.req1  : bus.req0;
      if (!mine_lock && (!mine_req || (other_req && waited >= MAX_HOLD - 1))) begin
        if (other_req) take(1 - owner);
        else begin owner = -1; waited = 0; end
      end else if (other_req && waited < 255) begin
        waited++;
      end
    end
  endtask

  function automatic arb_state_t exp_state();
    if (owner == 0) return ARB_OWN0;
    if (owner == 1) return ARB_OWN1;
    return ARB_IDLE;
  endfunction

  // ---------------- driver / checker ----------------
  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    logic [AW-1:0] ea, a;
    logic [DW-1:0] ed, d;
    logic          ew, w;
    #1;
    ea = '0; ed = '0; ew = 1'b0;
    if (owner == 0) begin
      ea = bus.addr0; ed = bus.wdata0; ew = bus.we0;
    end else if (owner == 1) begin
      ea = bus.addr1; ed = bus.wdata1;
      ew = bus.we1 && !(PROT_EN && int'(bus.addr1) <= PROT_TOP);
    end
    chk("mem_addr",  bus.mem_addr,  ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    chk("mem_write", bus.mem_write, ew);
    chk("rdata",     bus.rdata,     mem[ea]);
    if (ew) exp_q.push_back({ea, ed});
    w = bus.mem_write; a = bus.mem_addr; d = bus.mem_wdata;
    if (w) begin
      chk("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("write_payload", {a, d}, exp_q.pop_front());
    end
    @(posedge clk);
    if (w) mem[a] = d;
    model_edge();
    #1;
    chk("gnt0",       bus.gnt0,       32'(owner == 0));
    chk("gnt1",       bus.gnt1,       32'(owner == 1));
    chk("state",      dbg_state,      exp_state());
    chk("last_owner", dbg_last_owner, last);
    chk("prot_err",   bus.prot_err,   prot_exp);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_gnt0",      bus.gnt0,      0);
    chk("rst_gnt1",      bus.gnt1,      0);
    chk("rst_mem_write", bus.mem_write, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic set_idle_inputs();
    bus.req0 = 0; bus.lock0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 0; bus.lock1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int n;
    logic [DW-1:0] old10;
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom_range(0, 255));
    set_idle_inputs();
    reset = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("reset_gnt0",      bus.gnt0,       0);
    chk("reset_gnt1",      bus.gnt1,       0);
    chk("reset_state",     dbg_state,      ARB_IDLE);
    chk("reset_last",      dbg_last_owner, 1);
    chk("reset_mem_write", bus.mem_write,  0);
    chk("reset_prot_err",  bus.prot_err,   0);
    reset = 1'b0;

    // single request from port 0
    bus.req0 = 1; bus.addr0 = 8'h05;
    step();
    chk("t1_gnt0",  bus.gnt0,     1);
    chk("t1_gnt1",  bus.gnt1,     0);
    chk("t1_addr",  bus.mem_addr, 8'h05);
    chk("t1_rdata", bus.rdata,    mem[5]);
    bus.req0 = 0;
    step();

    // tie after reset goes to port 0, then direct handoff to port 1
    apply_reset();
    bus.req0 = 1; bus.req1 = 1;
    step();
    chk("tie_gnt0", bus.gnt0, 1);
    bus.req0 = 0;
    step();
    chk("handoff_gnt1", bus.gnt1, 1);
    chk("handoff_gnt0", bus.gnt0, 0);
    chk("handoff_last", dbg_last_owner, 1);

    // hold limit: port 0 keeps req, port 1 waits
    bus.req1 = 0;
    step();
    bus.req0 = 1; bus.req1 = 1;
    n = 0;
    for (int i = 0; i < 12 && !bus.gnt1; i++) begin
      step();
      if (bus.gnt0) n++;
    end
    chk("hold_cycles", n, MAX_HOLD);
    chk("hold_gnt1",   bus.gnt1, 1);

    // lock keeps port 0 on the bus with its request low
    bus.req1 = 0;
    step();
    chk("lock_pre_gnt0", bus.gnt0, 1);
    bus.lock0 = 1; bus.req0 = 0; bus.req1 = 1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.gnt0) n++;
    end
    chk("lock_cycles", n, 20);
    bus.lock0 = 0;
    step();
    chk("unlock_gnt1", bus.gnt1, 1);

    // port 1 write into the low (protectable) region
    old10 = mem[8'h10];
    bus.we1 = 1; bus.addr1 = 8'h10; bus.wdata1 = 8'hAA;
    step();
    bus.we1 = 0;
    step();
    chk("prot_mem10",   mem[8'h10],   PROT_EN ? old10 : 8'hAA);
    chk("prot_err",     bus.prot_err, PROT_EN);
    step();
    chk("prot_sticky",  bus.prot_err, PROT_EN);

    // reset in the middle of a port 1 write
    bus.we1 = 1; bus.addr1 = 8'h80; bus.wdata1 = DW'($urandom_range(0, 255));
    #2;
    chk("midwrite_active", bus.mem_write, 1);
    apply_reset();
    chk("post_reset_state", dbg_state, ARB_IDLE);
    bus.we1 = 0; bus.req0 = 1; bus.req1 = 1;
    step();
    chk("post_reset_tie", bus.gnt0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.req0   = ($urandom_range(0, 3) != 0);
      bus.lock0  = ($urandom_range(0, 7) == 0);
      bus.we0    = $urandom_range(0, 1) == 1;
      bus.addr0  = AW'($urandom_range(0, 255));
      bus.wdata0 = DW'($urandom_range(0, 255));
      bus.req1   = ($urandom_range(0, 3) != 0);
      bus.lock1  = ($urandom_range(0, 7) == 0);
      bus.we1    = $urandom_range(0, 1) == 1;
      bus.addr1  = AW'($urandom_range(0, 255));
      bus.wdata1 = DW'($urandom_range(0, 255));
      step();
    end

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
